// File: rtl/tmds_decoder.sv
// tmds_decoder: receive-side TMDS channel decoder (one instance per colour channel).
// Aligns the raw 10-bit deserializer output using control-token runs in blanking,
// then decodes each aligned word into 8b video data or a 2b control code.
// Optional build macro: TMDS_DECODER_DISPCHK_EN enables a running-disparity check.
//
// Ports:
//   clk_pixel    in   pixel clock, single clock domain
//   reset        in   asynchronous, active-high reset
//   raw_in       in   10-bit deserialized word, bit 0 earliest on the wire
//   vd_out       out  decoded video data (valid when vde_out = 1)
//   cd_out       out  decoded control code, {vsync,hsync} on blue (valid when vde_out = 0)
//   vde_out      out  1 = data word decoded, 0 = control token decoded
//   locked       out  symbol alignment acquired
//   align_sel    out  current bit offset into {raw_in, raw_prev}, 0..9
//   disp_err     out  one-cycle disparity error pulse (0 unless macro defined)
//   disp_err_cnt out  saturating disparity error count (0 unless macro defined)
//
// state  | meaning
// SEARCH | stepping through offsets, waiting for a run of LOCK_TOKENS tokens
// LOCKED | offset frozen; drops back to SEARCH after SEARCH_WINDOW token-free cycles
module tmds_decoder #(
   parameter int LOCK_TOKENS   = 16,
   parameter int SEARCH_WINDOW = 1024,
   parameter int MAX_DISP      = 12
) (
   input  logic       clk_pixel,
   input  logic       reset,
   input  logic [9:0] raw_in,
   output logic [7:0] vd_out,
   output logic [1:0] cd_out,
   output logic       vde_out,
   output logic       locked,
   output logic [3:0] align_sel,
   output logic       disp_err,
   output logic [7:0] disp_err_cnt
);

   localparam int CW = (SEARCH_WINDOW > 2) ? $clog2(SEARCH_WINDOW) : 1;
   localparam logic [CW-1:0] WIN_LAST = CW'(SEARCH_WINDOW - 1);
   localparam logic [CW-1:0] RUN_LAST = CW'(LOCK_TOKENS - 1);

   if (LOCK_TOKENS < 1 || SEARCH_WINDOW <= LOCK_TOKENS || MAX_DISP < 1) begin : g_bad_cfg
      $error("tmds_decoder: inconsistent parameter set");
   end

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [9:0]    raw_prev;
   logic [19:0]   window_sh;
   logic [9:0]    word;
   logic          is_token;
   logic [1:0]    code;
   logic [7:0]    d, q;
   logic [CW-1:0] run_cnt, run_nxt, win_cnt, win_nxt;
   logic [3:0]    sel_nxt;

   always_comb begin
      window_sh = {raw_in, raw_prev} >> align_sel;
      word      = window_sh[9:0];
   end

   always_comb begin
      is_token = 1'b1;
      code     = 2'b00;
      case (word)
         10'b1101010100: code = 2'b00;
         10'b0010101011: code = 2'b01;
         10'b0101010100: code = 2'b10;
         10'b1010101011: code = 2'b11;
         default:        is_token = 1'b0;
      endcase
   end

   always_comb begin
      d    = word[9] ? ~word[7:0] : word[7:0];
      q    = '0;
      q[0] = d[0];
      for (int i = 1; i < 8; i++)
         q[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = align_sel;
      run_nxt   = is_token ? run_cnt + CW'(1) : '0;
      win_nxt   = win_cnt + CW'(1);
      case (state)
         SEARCH: begin
            // Lock takes priority over a window expiring on the same cycle.
            if (is_token && run_cnt == RUN_LAST) begin
               state_nxt = LOCKED;
               run_nxt   = '0;
               win_nxt   = '0;
            end else if (win_cnt == WIN_LAST) begin
               sel_nxt = (align_sel == 4'd9) ? 4'd0 : align_sel + 4'd1;
               run_nxt = '0;
               win_nxt = '0;
            end
         end
         LOCKED: begin
            if (is_token) begin
               win_nxt = '0;
            end else if (win_cnt == WIN_LAST) begin
               state_nxt = SEARCH;
               run_nxt   = '0;
               win_nxt   = '0;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state     <= SEARCH;
         raw_prev  <= '0;
         align_sel <= '0;
         run_cnt   <= '0;
         win_cnt   <= '0;
         locked    <= 1'b0;
         vd_out    <= '0;
         cd_out    <= '0;
         vde_out   <= 1'b0;
      end else begin
         state     <= state_nxt;
         raw_prev  <= raw_in;
         align_sel <= sel_nxt;
         run_cnt   <= run_nxt;
         win_cnt   <= win_nxt;
         locked    <= (state_nxt == LOCKED);
         if (is_token) begin
            vde_out <= 1'b0;
            cd_out  <= code;
         end else begin
            vde_out <= 1'b1;
            vd_out  <= q;
         end
      end
   end

`ifdef TMDS_DECODER_DISPCHK_EN
   logic signed [5:0] acc, acc_next, acc_abs;
   logic [3:0]        ones;
   logic              err_nxt;

   always_comb begin
      ones = '0;
      for (int i = 0; i < 10; i++)
         ones = ones + 4'(word[i]);
      acc_next = acc + $signed(6'(ones)) - 6'sd5;
      acc_abs  = acc_next[5] ? -acc_next : acc_next;
      err_nxt  = !is_token && ($unsigned(acc_abs) > 6'(MAX_DISP));
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         acc          <= '0;
         disp_err     <= 1'b0;
         disp_err_cnt <= '0;
      end else if (is_token) begin
         acc      <= '0;
         disp_err <= 1'b0;
      end else if (err_nxt) begin
         acc      <= '0;
         disp_err <= 1'b1;
         if (disp_err_cnt != 8'hFF)
            disp_err_cnt <= disp_err_cnt + 8'd1;
      end else begin
         acc      <= acc_next;
         disp_err <= 1'b0;
      end
   end
`else
   assign disp_err     = 1'b0;
   assign disp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed testbench for tmds_decoder: reset, alignment search/lock,
// data/control decode, window wrap, loss of lock and disparity checking.
module tb_tmds_decoder;
   localparam int SW = 1024;
   localparam int LT = 16;

   localparam logic [9:0] TOK00   = 10'h354;  // 1101010100
   localparam logic [9:0] TOK11   = 10'h2AB;  // 1010101011
   localparam logic [9:0] TOK00_S3 = 10'h2A6; // TOK00 stream slipped by 3 bits
   localparam logic [9:0] W_100   = 10'h100;  // -> 0x00
   localparam logic [9:0] W_200   = 10'h200;  // -> 0xFF
   localparam logic [9:0] W_101   = 10'h101;  // -> 0x03
   localparam logic [9:0] W_3FC   = 10'h3FC;  // -> 0x05, popcount 8

   logic       clk_pixel = 1'b0;
   logic       reset;
   logic [9:0] raw_in;
   logic [7:0] vd_out;
   logic [1:0] cd_out;
   logic       vde_out;
   logic       locked;
   logic [3:0] align_sel;
   logic       disp_err;
   logic [7:0] disp_err_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   logic       exp_err;
   logic [7:0] exp_cnt;

   tmds_decoder dut (
      .clk_pixel    (clk_pixel),
      .reset        (reset),
      .raw_in       (raw_in),
      .vd_out       (vd_out),
      .cd_out       (cd_out),
      .vde_out      (vde_out),
      .locked       (locked),
      .align_sel    (align_sel),
      .disp_err     (disp_err),
      .disp_err_cnt (disp_err_cnt)
   );

   always #5 clk_pixel = ~clk_pixel;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one word, then advance to just after the next rising edge.
   task automatic step(input logic [9:0] w);
      raw_in = w;
      @(posedge clk_pixel);
      #1;
   endtask

   initial begin
`ifdef TMDS_DECODER_DISPCHK_EN
      exp_err = 1'b1;
      exp_cnt = 8'd1;
`else
      exp_err = 1'b0;
      exp_cnt = 8'd0;
`endif
      reset  = 1'b1;
      raw_in = '0;
      repeat (2) @(posedge clk_pixel);
      #1;
      check("rst_vd", vd_out, 8'h00);
      check("rst_cd", cd_out, 2'b00);
      check("rst_vde", vde_out, 1'b0);
      check("rst_locked", locked, 1'b0);
      check("rst_sel", align_sel, 4'd0);
      check("rst_derr", disp_err, 1'b0);
      check("rst_dcnt", disp_err_cnt, 8'd0);
      reset = 1'b0;

      // Aligned token stream locks at offset 0.
      cyc = 0;
      while (!locked && cyc < 4*SW + LT + 2) begin
         step(TOK00);
         cyc++;
      end
      check("lock0_locked", locked, 1'b1);
      check("lock0_not_early", (cyc >= LT), 1'b1);
      check("lock0_sel", align_sel, 4'd0);
      check("lock0_cd", cd_out, 2'b00);
      check("lock0_vde", vde_out, 1'b0);

      // Decode with two-edge latency.
      step(W_100);
      check("lat_vde", vde_out, 1'b0);
      step(W_200);
      check("dec100_vde", vde_out, 1'b1);
      check("dec100_vd", vd_out, 8'h00);
      check("dec100_cd_held", cd_out, 2'b00);
      step(W_101);
      check("dec200_vd", vd_out, 8'hFF);
      step(TOK11);
      check("dec101_vd", vd_out, 8'h03);
      step(TOK00);
      check("tok11_vde", vde_out, 1'b0);
      check("tok11_cd", cd_out, 2'b11);
      check("tok11_vd_held", vd_out, 8'h03);
      step(TOK00);
      check("tok00_cd", cd_out, 2'b00);
      check("locked_through_data", locked, 1'b1);

      // Running disparity: +3 per word, limit exceeded on the fifth word.
      repeat (5) step(W_3FC);
      check("disp_before", disp_err, 1'b0);
      step(W_3FC);
      check("disp_pulse", disp_err, exp_err);
      check("disp_cnt", disp_err_cnt, exp_cnt);
      check("disp_vd", vd_out, 8'h05);
      check("disp_vde", vde_out, 1'b1);
      step(W_3FC);
      check("disp_one_cycle", disp_err, 1'b0);
      check("disp_cnt_hold", disp_err_cnt, exp_cnt);

      // Loss of lock after SEARCH_WINDOW token-free cycles, offset retained.
      repeat (2) step(TOK00);
      repeat (SW - 4) step(W_200);
      check("lol_still_locked", locked, 1'b1);
      repeat (8) step(W_200);
      check("lol_unlocked", locked, 1'b0);
      check("lol_sel_kept", align_sel, 4'd0);
      repeat (LT - 1) step(TOK00);
      check("relock_not_early", locked, 1'b0);
      repeat (3) step(TOK00);
      check("relock_locked", locked, 1'b1);
      check("relock_sel", align_sel, 4'd0);
      check("relock_vd_held", vd_out, 8'hFF);

      // Asynchronous reset between clock edges.
      #2;
      reset = 1'b1;
      #1;
      check("arst_locked", locked, 1'b0);
      check("arst_vd", vd_out, 8'h00);
      check("arst_vde", vde_out, 1'b0);
      check("arst_cd", cd_out, 2'b00);
      check("arst_sel", align_sel, 4'd0);
      check("arst_dcnt", disp_err_cnt, 8'd0);
      @(posedge clk_pixel);
      #1;
      reset = 1'b0;

      // Token stream slipped by three bits locks at offset 3.
      cyc = 0;
      while (!locked && cyc < 4*SW + LT + 2) begin
         step(TOK00_S3);
         cyc++;
      end
      check("lock3_locked", locked, 1'b1);
      check("lock3_sel", align_sel, 4'd3);
      check("lock3_cd", cd_out, 2'b00);
      check("lock3_vde", vde_out, 1'b0);

      // No tokens anywhere: lose lock, walk offsets, wrap 9 -> 0.
      cyc = 0;
      while (align_sel != 4'd9 && cyc < 8*SW + 16) begin
         step(W_200);
         cyc++;
      end
      check("walk_sel9", align_sel, 4'd9);
      check("walk_unlocked", locked, 1'b0);
      repeat (SW - 4) step(W_200);
      check("wrap_not_early", align_sel, 4'd9);
      repeat (8) step(W_200);
      check("wrap_sel0", align_sel, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
